// File: rtl/id_ex_latch.sv
// ----------------------------------------------------------------------------
// id_ex_latch
//   ID/EX pipeline register with load-use hazard detection, flush and EX hold.
//   Each clock edge applies exactly one action: flush > ex_hold > hazard > load.
//   Flush, hazard and an empty ID slot all insert a bubble; only a hazard
//   bubble is counted in bubble_cnt, which saturates instead of wrapping.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   flush                : branch/jump redirect from EX, kills the ID instruction
//   ex_hold              : EX busy, freezes the latch
//   id_*                 : decoded instruction fields from ID
//   ex_*                 : registered EX-stage copies of id_*
//   stall_id             : combinational, holds PC and IF/ID this cycle
//   bubble_cnt           : saturating count of load-use bubbles
// ----------------------------------------------------------------------------
module id_ex_latch #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             ex_hold,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_use_imm,
    input  logic             id_reg_we,
    input  logic             id_mem_re,
    input  logic             id_mem_we,
    input  logic [3:0]       id_alu_op,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_imm,
    output logic             ex_use_imm,
    output logic             ex_reg_we,
    output logic             ex_mem_re,
    output logic             ex_mem_we,
    output logic [3:0]       ex_alu_op,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic             stall_id,
    output logic [CNT_W-1:0] bubble_cnt
);

    // All-zero encoding is the bubble: x0 indices never match forwarding.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            reg_we;
        logic            mem_re;
        logic            mem_we;
        logic [3:0]      alu_op;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } ex_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    ex_t              r_ex;
    logic [CNT_W-1:0] r_bubble_cnt;
    ex_t              w_id;
    logic             w_hazard;

    always_comb begin
        w_id          = '0;
        w_id.valid    = 1'b1;
        w_id.pc       = id_pc;
        w_id.rs1      = id_rs1;
        w_id.rs2      = id_rs2;
        w_id.rd       = id_rd;
        w_id.imm      = id_imm;
        w_id.use_imm  = id_use_imm;
        w_id.reg_we   = id_reg_we;
        w_id.mem_re   = id_mem_re;
        w_id.mem_we   = id_mem_we;
        w_id.alu_op   = id_alu_op;
        w_id.rs1_data = id_rs1_data;
        w_id.rs2_data = id_rs2_data;
    end

    // rs2 is irrelevant when operand B comes from the immediate.
    assign w_hazard = id_valid && r_ex.valid && r_ex.mem_re && (r_ex.rd != 5'd0) &&
                      ((r_ex.rd == id_rs1) || (!id_use_imm && (r_ex.rd == id_rs2)));

    // A flush discards the ID instruction, so there is nothing to hold upstream.
    assign stall_id = !flush && (ex_hold || w_hazard);

    // ID -> EX register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex         <= '0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_ex <= '0;
        end else if (ex_hold) begin
            r_ex <= r_ex;
        end else if (w_hazard) begin
            r_ex         <= '0;
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
        end else begin
            r_ex <= id_valid ? w_id : '0;
        end
    end

    assign ex_valid    = r_ex.valid;
    assign ex_pc       = r_ex.pc;
    assign ex_rs1      = r_ex.rs1;
    assign ex_rs2      = r_ex.rs2;
    assign ex_rd       = r_ex.rd;
    assign ex_imm      = r_ex.imm;
    assign ex_use_imm  = r_ex.use_imm;
    assign ex_reg_we   = r_ex.reg_we;
    assign ex_mem_re   = r_ex.mem_re;
    assign ex_mem_we   = r_ex.mem_we;
    assign ex_alu_op   = r_ex.alu_op;
    assign ex_rs1_data = r_ex.rs1_data;
    assign ex_rs2_data = r_ex.rs2_data;
    assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_latch.sv
// ----------------------------------------------------------------------------
// tb_id_ex_latch
//   Scoreboard bench for id_ex_latch. A reference model predicts the EX state
//   and bubble count for every clock; the prediction is queued when the inputs
//   are driven and compared after the edge. stall_id is compared combinationally
//   before each edge. The counter is built narrow (CNT_W=4) so saturation is
//   reached in a few dozen cycles; 0xE/0xF play the role of 0xFFFE/0xFFFF.
// ----------------------------------------------------------------------------
module tb_id_ex_latch;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            reg_we;
        logic            mem_re;
        logic            mem_we;
        logic [3:0]      alu_op;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
    } ex_t;

    typedef struct packed {
        ex_t              ex;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             ex_hold;
    ex_t              id_s;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic [XLEN-1:0]  ex_imm;
    logic             ex_use_imm;
    logic             ex_reg_we;
    logic             ex_mem_re;
    logic             ex_mem_we;
    logic [3:0]       ex_alu_op;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic             stall_id;
    logic [CNT_W-1:0] bubble_cnt;

    ex_t              m_ex;
    logic [CNT_W-1:0] m_cnt;
    exp_t             sb_q[$];
    int               n_cmp = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    id_ex_latch #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .ex_hold    (ex_hold),
        .id_valid   (id_s.valid),
        .id_pc      (id_s.pc),
        .id_rs1     (id_s.rs1),
        .id_rs2     (id_s.rs2),
        .id_rd      (id_s.rd),
        .id_imm     (id_s.imm),
        .id_use_imm (id_s.use_imm),
        .id_reg_we  (id_s.reg_we),
        .id_mem_re  (id_s.mem_re),
        .id_mem_we  (id_s.mem_we),
        .id_alu_op  (id_s.alu_op),
        .id_rs1_data(id_s.rs1_data),
        .id_rs2_data(id_s.rs2_data),
        .ex_valid   (ex_valid),
        .ex_pc      (ex_pc),
        .ex_rs1     (ex_rs1),
        .ex_rs2     (ex_rs2),
        .ex_rd      (ex_rd),
        .ex_imm     (ex_imm),
        .ex_use_imm (ex_use_imm),
        .ex_reg_we  (ex_reg_we),
        .ex_mem_re  (ex_mem_re),
        .ex_mem_we  (ex_mem_we),
        .ex_alu_op  (ex_alu_op),
        .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data),
        .stall_id   (stall_id),
        .bubble_cnt (bubble_cnt)
    );

    ex_t w_dut_ex;
    assign w_dut_ex = '{valid: ex_valid, pc: ex_pc, rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd,
                        imm: ex_imm, use_imm: ex_use_imm, reg_we: ex_reg_we,
                        mem_re: ex_mem_re, mem_we: ex_mem_we, alu_op: ex_alu_op,
                        rs1_data: ex_rs1_data, rs2_data: ex_rs2_data};

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic use_imm, input logic mem_re);
        id_s          = '0;
        id_s.valid    = v;
        id_s.pc       = pc;
        id_s.rs1      = rs1;
        id_s.rs2      = rs2;
        id_s.rd       = rd;
        id_s.imm      = pc ^ 32'h0000_0055;
        id_s.use_imm  = use_imm;
        id_s.reg_we   = 1'b1;
        id_s.mem_re   = mem_re;
        id_s.alu_op   = pc[3:0];
        id_s.rs1_data = $urandom;
        id_s.rs2_data = $urandom;
    endtask

    // Called just after a falling edge: predict, clock once, compare.
    task automatic step(input string tag, input logic f, input logic h);
        logic hz;
        exp_t e;
        flush   = f;
        ex_hold = h;
        #1;
        hz = m_ex.valid && m_ex.mem_re && (m_ex.rd != 5'd0) && id_s.valid &&
             ((m_ex.rd == id_s.rs1) || (!id_s.use_imm && (m_ex.rd == id_s.rs2)));
        check({tag, ".stall"}, 200'(stall_id), 200'(!f && (h || hz)));
        if (f)       m_ex = '0;
        else if (h)  m_ex = m_ex;
        else if (hz) begin
            m_ex = '0;
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end else     m_ex = id_s.valid ? id_s : '0;
        e.ex  = m_ex;
        e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check({tag, ".queue"}, 200'(0), 200'(1));
        end else begin
            e = sb_q.pop_front();
            check({tag, ".ex"}, 200'({w_dut_ex, bubble_cnt}), 200'(e));
        end
    endtask

    // Reset asserted between edges, held across one rising edge, released at a falling edge.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        m_ex  = '0;
        m_cnt = '0;
        check({tag, ".valid"}, 200'(ex_valid), 200'(0));
        check({tag, ".cnt"},   200'(bubble_cnt), 200'(0));
        check({tag, ".stall"}, 200'(stall_id), 200'(!flush && ex_hold));
        check({tag, ".ex"},    200'(w_dut_ex), 200'(m_ex));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        ex_hold = 1'b0;
        m_ex    = '0;
        m_cnt   = '0;
        set_id(1'b1, 32'h40, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0);
        #2;
        check("rst.ex",    200'({w_dut_ex, bubble_cnt}), 200'(0));
        check("rst.stall", 200'(stall_id), 200'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Plain load
        set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        step("load", 1'b0, 1'b0);
        check("load.pc", 200'(ex_pc), 200'(32'h100));

        // Load-use on rs1: one bubble, then the same instruction loads
        set_id(1'b1, 32'h104, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        step("lw_x3", 1'b0, 1'b0);
        set_id(1'b1, 32'h108, 5'd3, 5'd2, 5'd4, 1'b0, 1'b0);
        step("lu_bubble", 1'b0, 1'b0);
        step("lu_retry", 1'b0, 1'b0);
        check("lu.rs1", 200'(ex_rs1), 200'(5'd3));

        // Load-use on rs2
        set_id(1'b1, 32'h10c, 5'd0, 5'd0, 5'd7, 1'b0, 1'b1);
        step("lw_x7", 1'b0, 1'b0);
        set_id(1'b1, 32'h110, 5'd1, 5'd7, 5'd8, 1'b0, 1'b0);
        step("rs2_bubble", 1'b0, 1'b0);
        step("rs2_retry", 1'b0, 1'b0);

        // Immediate operand ignores rs2
        set_id(1'b1, 32'h114, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        step("lw_x3b", 1'b0, 1'b0);
        set_id(1'b1, 32'h118, 5'd1, 5'd3, 5'd4, 1'b1, 1'b0);
        step("imm_immune", 1'b0, 1'b0);

        // Load to x0 never stalls
        set_id(1'b1, 32'h11c, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
        step("lw_x0", 1'b0, 1'b0);
        set_id(1'b1, 32'h120, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        step("x0_immune", 1'b0, 1'b0);

        // Empty ID slot: bubble, not counted
        set_id(1'b1, 32'h124, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        step("lw_x3c", 1'b0, 1'b0);
        set_id(1'b0, 32'h128, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0);
        step("id_empty", 1'b0, 1'b0);

        // Flush beats hold and hazard
        set_id(1'b1, 32'h12c, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        step("lw_x3d", 1'b0, 1'b0);
        set_id(1'b1, 32'h130, 5'd3, 5'd2, 5'd4, 1'b0, 1'b0);
        step("flush_prio", 1'b1, 1'b1);

        // Hold freezes the latch over a pending hazard
        set_id(1'b1, 32'h134, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        step("lw_x3e", 1'b0, 1'b0);
        set_id(1'b1, 32'h138, 5'd3, 5'd2, 5'd4, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b1);
        step("hold_release", 1'b0, 1'b0);
        step("hold_retry", 1'b0, 1'b0);

        // Reset in the middle of a stall
        set_id(1'b1, 32'h13c, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        step("lw_x3f", 1'b0, 1'b0);
        set_id(1'b1, 32'h140, 5'd3, 5'd2, 5'd4, 1'b0, 1'b0);
        async_reset("rst_stall");
        step("post_rst", 1'b0, 1'b0);

        // Drive the counter into saturation
        for (int i = 0; i < 17; i++) begin
            set_id(1'b1, 32'h200 + 32'(8 * i), 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
            step("sat_lw", 1'b0, 1'b0);
            set_id(1'b1, 32'h204 + 32'(8 * i), 5'd3, 5'd2, 5'd4, 1'b0, 1'b0);
            step("sat_hz", 1'b0, 1'b0);
        end
        check("sat.cnt", 200'(bubble_cnt), 200'({CNT_W{1'b1}}));
        async_reset("rst_sat");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            set_id(($urandom_range(0, 9) != 0), $urandom, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step("rand", ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
        end

        check("sb.empty", 200'(sb_q.size()), 200'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/id_ex_latch.md
ID_EX_LATCH -- requirements
Module: id_ex_latch

Interface
REQ-001 Parameter: XLEN, 32, datapath/PC/immediate width.
REQ-002 Parameter: CNT_W, 16, bubble counter width.
REQ-003 Ports, one clock; reset is asynchronous and active-low:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  branch/jump redirect from EX; kill ID instruction
- ex_hold  in  1  EX stage busy; freeze latch
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_imm  in  XLEN  decoded immediate
- id_use_imm  in  1  operand B is immediate
- id_reg_we, id_mem_re, id_mem_we  in  1  control bits
- id_alu_op  in  4  ALU operation
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_imm, ex_use_imm, ex_reg_we, ex_mem_re, ex_mem_we, ex_alu_op, ex_rs1_data, ex_rs2_data  out  (widths as id_*)  registered EX-stage copies
- stall_id  out  1  hold PC and IF/ID latch this cycle
- bubble_cnt  out  CNT_W  count of load-use bubbles inserted

Function
REQ-010 Load-use hazard (combinational) SHALL be: id_valid && ex_valid && ex_mem_re && ex_rd!=0 && (ex_rd==id_rs1 || (!id_use_imm && ex_rd==id_rs2)).
REQ-011 stall_id SHALL equal !flush && (ex_hold || hazard); purely combinational, no registered delay.
REQ-012 Each rising clk edge SHALL apply exactly one action, priority order: flush > ex_hold > hazard > load.
REQ-013 flush: latch SHALL load a bubble regardless of ex_hold or hazard.
REQ-014 ex_hold (no flush): all ex_* outputs SHALL keep their values; bubble_cnt unchanged.
REQ-015 hazard (no flush, no ex_hold): latch SHALL load a bubble; bubble_cnt SHALL increment by 1.
REQ-016 load: if id_valid=1, every ex_* SHALL take the corresponding id_* value and ex_valid=1; if id_valid=0, latch SHALL load a bubble without incrementing bubble_cnt.
REQ-017 Bubble SHALL be: ex_valid=0, ex_reg_we=0, ex_mem_re=0, ex_mem_we=0, ex_rs1=ex_rs2=ex_rd=0, ex_use_imm=0, ex_alu_op=0, ex_pc/ex_imm/ex_rs1_data/ex_rs2_data=0 (x0 indices guarantee no downstream forwarding match).
REQ-018 Latency ID->EX SHALL be exactly one cycle on load; a load-use stall SHALL cost exactly one bubble, after which the same ID instruction loads (hazard clears because EX now holds the bubble).
REQ-019 bubble_cnt SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-020 Hazard compare SHALL ignore id_rs2 when id_use_imm=1 and SHALL never fire for ex_rd=0.

Reset
REQ-030 rst_n low SHALL asynchronously force a bubble on all ex_* outputs and bubble_cnt=0, independent of clk.
REQ-031 stall_id during reset SHALL be 0 (ex_valid=0 prevents hazard; ex_hold/flush inputs still pass per REQ-011).
REQ-032 Reset deasserted mid-stall SHALL resume with a clean bubble state; no stale hazard is retained.

Verification
REQ-040 Plain load: id_valid=1, id_pc=0x100, id_rd=5, id_reg_we=1 -> next cycle ex_pc=0x100, ex_rd=5, ex_valid=1, stall_id=0.
REQ-041 Load-use: EX holds lw x3 (ex_mem_re=1, ex_rd=3); ID add x4,x3,x2 -> stall_id=1, next cycle ex_valid=0, bubble_cnt=1; following cycle ex_rs1=3, stall_id=0.
REQ-042 Immediate immunity: EX lw x3; ID addi x4,x1,imm with id_rs2=3, id_use_imm=1 -> stall_id=0, no bubble; same with ex_rd=0 -> no stall.
REQ-043 Priority: flush=1 with hazard and ex_hold=1 -> stall_id=0, next cycle bubble, bubble_cnt unchanged; ex_hold=1 alone for 3 cycles -> ex_* constant, stall_id=1 each cycle.
REQ-044 Saturation/reset: preload bubble_cnt to 0xFFFE, force 3 hazards -> 0xFFFF; assert rst_n=0 between clk edges -> ex_valid=0 and bubble_cnt=0 immediately.
